fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Consumer of the branch redirect (branch_taken, branch_addr) and producer of the instruction stream for decode in the RV32E core.
- Owns the fetch PC and issues in-order word requests to instruction memory.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- On a redirect, flushes buffered instructions, discards stale in-flight responses and restarts fetch at the branch target.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction buffer entries (power of two, >= 2).
- MAX_OUTSTANDING, 2, maximum imem requests in flight (1..FIFO_DEPTH).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- branch_taken  in  1  redirect strobe from the brancher, registered upstream, one-cycle pulse.
- branch_addr  in  32  redirect target, valid when branch_taken=1.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  word address of the request.
- imem_rsp_valid  in  1  response strobe; always accepted, no backpressure.
- imem_rsp_data  in  32  instruction word.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts.
- if_instr  out  32  instruction (0 when if_fault=1).
- if_pc  out  32  PC of if_instr.
- if_fault  out  1  instruction-address-misaligned marker.

Behaviour:
- Reset (async assert, sync release):
  - Registered state: pc=RESET_PC, FIFO empty, outstanding=0, drop=0, halted=0.
  - Outputs while rst_n=0: imem_req_valid=0, if_valid=0, if_fault=0, if_instr=0, if_pc=0.
  - Responses to pre-reset requests are illegal; memory shares rst_n.
- Request issue:
  - imem_req_valid = !halted && outstanding < MAX_OUTSTANDING && (fifo_count + outstanding) < FIFO_DEPTH.
  - imem_req_addr = pc.
  - On req handshake: pc <= pc+4 (mod 2^32, wraps to 0), outstanding++.
  - The issued address is pushed to an internal in-flight address queue of depth MAX_OUTSTANDING.
- Responses:
  - Returned in request order, at least 1 cycle after the request.
  - Each response: outstanding--, pop the address queue.
  - If drop>0: drop--, data discarded.
  - Otherwise push {addr, data, fault=0} into the FIFO.
  - The credit rule guarantees the FIFO never overflows; a push into a full FIFO is an assertion failure.
- Output:
  - if_valid = FIFO non-empty; the head drives if_instr, if_pc and if_fault.
  - Pop on if_valid && if_ready.
  - Latency: rsp -> if_valid is 1 cycle.
  - Simultaneous push and pop leave count unchanged.
  - Redirect -> first request is 1 cycle; minimum redirect -> if_valid is 3 cycles with a 1-cycle memory.
- Redirect (branch_taken=1 at a posedge):
  - FIFO cleared and pc <= branch_addr.
  - drop <= outstanding count after this cycle's request and response updates. A request accepted in the redirect cycle is stale; a response arriving in the redirect cycle is discarded.
  - A decode handshake in the redirect cycle counts as consumed; downstream kills it.
  - Redirect overrides any pending drop count (recomputed, never summed) and clears halted.
- Misaligned target (branch_addr[1:0] != 0):
  - halted <= 1 and no further requests are issued.
  - The FIFO is loaded with a single entry {pc=branch_addr, instr=0, fault=1}, visible the next cycle.
  - Stale responses continue to drain via drop.
  - The fault entry may be popped; fetch stays halted until the next redirect.
- Counter widths: outstanding and drop are $clog2(MAX_OUTSTANDING+1) bits; FIFO pointers are $clog2(FIFO_DEPTH) bits plus a wrap bit.

Decomposition:
- Shared package fetch_pkg holds:
  - fetch_entry_t {pc[31:0], instr[31:0], fault}.
  - FETCH_WORD_BYTES=4.
  - RESET_PC default.
  - MISALIGN_MASK=2'b11.
- Sub-module sync_fifo (parameterised width/depth, flush input, count output) is instantiated twice: the instruction buffer and the in-flight address queue.

Test Plan:
- Straight-line fetch: reset, memory ready always, 1-cycle latency, if_ready=1 → if_pc sequence 0,4,8,12… with no bubbles after fill; outstanding never exceeds 2.
- Backpressure: if_ready=0 for 10 cycles → exactly 4 requests issued (addrs 0..12), imem_req_valid then 0. Release → requests resume at 16, in order, none lost.
- Redirect with 2 in flight: branch_taken with branch_addr=0x100 while 2 responses are pending → both discarded. Next imem_req_addr=0x100; the first if_pc after redirect is 0x100.
- Same-cycle events: redirect in the same cycle as a req handshake and a response → that response is dropped and the new request is counted stale. drop=2 (1 old outstanding + the new request); the first delivered if_pc equals the target.
- Misaligned target: branch_addr=0x102 → if_valid with if_fault=1, if_pc=0x102, if_instr=0; no further imem requests. A later redirect to 0x200 resumes fetch.
- Reset mid-operation: assert rst_n=0 with FIFO half-full and 1 outstanding → outputs zero immediately. After release the first request is at RESET_PC and FIFO_count=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned FETCH_WORD_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [1:0]  MISALIGN_MASK    = 2'b11;

  // One buffered instruction as presented to decode.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Redirect, instruction-memory and decode handshake signals of the fetch unit.
interface fetch_unit_if;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;

  // Fetch-unit side.
  modport master (
    input  branch_taken, branch_addr, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_fault
  );

  // Environment side: brancher, instruction memory and decode.
  modport slave (
    output branch_taken, branch_addr, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_fault
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush and occupancy count. Depth must be a power of two.
// A flush that coincides with a push leaves exactly the pushed entry in the FIFO.
module sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(Depth):0] count_o
);
  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [CW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW-1:0]    waddr;

  assign count_o = wptr_q - rptr_q;
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (count_o == CW'(Depth));
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // Pointer update; flush restarts both pointers at slot 0.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    waddr  = wptr_q[AW-1:0];
    if (flush_i) begin
      rptr_d = '0;
      waddr  = '0;
      wptr_d = push_i ? CW'(1) : '0;
    end else begin
      if (push_i) wptr_d = wptr_q + CW'(1);
      if (pop_i && !empty_o) rptr_d = rptr_q + CW'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: entries are only read once the pointers cover them.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[waddr] <= wdata_i;
  end

  // Upstream credit accounting must keep pushes away from a full FIFO.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: owns the PC, issues in-order word requests to instruction memory, buffers
// responses and hands them to decode. Redirects flush the buffer and drop stale responses.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);
  localparam int unsigned OW      = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned IbCw    = $clog2(FIFO_DEPTH) + 1;
  // Address queue rounded up to a power of two; credits keep it at most MAX_OUTSTANDING full.
  localparam int unsigned AqDepth = (MAX_OUTSTANDING < 2) ? 2 : 2 ** $clog2(MAX_OUTSTANDING);
  localparam int unsigned AqCw    = $clog2(AqDepth) + 1;

  logic [31:0]     pc_q, pc_d;
  logic [OW-1:0]   out_q, out_d;
  logic [OW-1:0]   drop_q, drop_d;
  logic            halted_q, halted_d;

  logic            req_fire, rsp_drop, misaligned;
  logic [31:0]     credit_used;
  logic [31:0]     aq_head;
  logic [AqCw-1:0] aq_count;
  logic            aq_empty, aq_full;
  fetch_entry_t    ib_wdata, ib_head;
  logic            ib_push, ib_pop, ib_empty, ib_full;
  logic [IbCw-1:0] ib_count;
  logic            unused_flags;

  assign unused_flags = ^{aq_count, aq_empty, aq_full, ib_full};

  assign misaligned  = (bus.branch_addr[1:0] & MISALIGN_MASK) != 2'b00;
  // Buffered plus in-flight words must fit in the buffer so every response has a slot.
  assign credit_used = 32'(ib_count) + 32'(out_q);

  // rst_n gates the request so memory sees nothing while reset is asserted.
  assign bus.imem_req_valid = rst_n && !halted_q && (32'(out_q) < MAX_OUTSTANDING) &&
                              (credit_used < FIFO_DEPTH);
  assign bus.imem_req_addr  = pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_drop           = bus.imem_rsp_valid && (drop_q != '0);

  assign bus.if_valid = !ib_empty;
  assign bus.if_instr = (bus.if_valid && !ib_head.fault) ? ib_head.instr : 32'h0;
  assign bus.if_pc    = bus.if_valid ? ib_head.pc : 32'h0;
  assign bus.if_fault = bus.if_valid && ib_head.fault;
  assign ib_pop       = bus.if_valid && bus.if_ready;

  // Next PC, in-flight count, drop count and halt flag; a redirect overrides all of them.
  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    out_d    = out_q + OW'(req_fire) - OW'(bus.imem_rsp_valid);
    drop_d   = drop_q - OW'(rsp_drop);
    if (req_fire) pc_d = pc_q + FETCH_WORD_BYTES;
    if (bus.branch_taken) begin
      pc_d     = bus.branch_addr;
      halted_d = misaligned;
      drop_d   = out_d;
    end
  end

  // Buffer write: live response data, or the fault marker for a misaligned target.
  always_comb begin
    ib_push  = bus.imem_rsp_valid && !rsp_drop;
    ib_wdata = '{pc: aq_head, instr: bus.imem_rsp_data, fault: 1'b0};
    if (bus.branch_taken) begin
      ib_push  = misaligned;
      ib_wdata = '{pc: bus.branch_addr, instr: 32'h0, fault: 1'b1};
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      halted_q <= halted_d;
    end
  end

  // Addresses of requests in flight; never flushed so stale responses still pop their entry.
  sync_fifo #(
    .Width (32),
    .Depth (AqDepth)
  ) u_addr_q (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (1'b0),
    .push_i  (req_fire),
    .wdata_i (pc_q),
    .pop_i   (bus.imem_rsp_valid),
    .rdata_o (aq_head),
    .empty_o (aq_empty),
    .full_o  (aq_full),
    .count_o (aq_count)
  );

  // Instruction buffer towards decode.
  sync_fifo #(
    .Width ($bits(fetch_entry_t)),
    .Depth (FIFO_DEPTH)
  ) u_instr_buf (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (bus.branch_taken),
    .push_i  (ib_push),
    .wdata_i (ib_wdata),
    .pop_i   (ib_pop),
    .rdata_o (ib_head),
    .empty_o (ib_empty),
    .full_o  (ib_full),
    .count_o (ib_count)
  );

endmodule
